// File: rtl/scanner_pkg.sv
// Shared definitions for the scanner link: FSM states, transfer steps and command codes.
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STANDBY  = 2'd2,
    TRANSFER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    XF_CMD     = 2'd0,
    XF_PAYLOAD = 2'd1,
    XF_DRAIN   = 2'd2
  } xfer_step_t;

  localparam int CMD_READY = 2;
  localparam int CMD_START = 3;
  localparam int CMD_FULL  = 4;
  localparam int CMD_DATA  = 7;

endpackage

// File: rtl/scanner_link_if.sv
// Scan-control strobes, serial link pins and status bundled between the fabric and the scanner node.
interface scanner_link_if #(
  parameter int FILL_W = 4
);
  logic              start_i;
  logic              peer_half_i;
  logic              ready_xfer_i;
  logic              ser_clk_o;
  logic              ser_data_o;
  logic              busy_o;
  logic [1:0]        state_o;
  logic [FILL_W-1:0] fill_o;

  modport master (
    output start_i, peer_half_i, ready_xfer_i,
    input  ser_clk_o, ser_data_o, busy_o, state_o, fill_o
  );

  modport slave (
    input  start_i, peer_half_i, ready_xfer_i,
    output ser_clk_o, ser_data_o, busy_o, state_o, fill_o
  );
endinterface

// File: rtl/scanner_ser_tx.sv
// W-bit LSB-first frame serializer: two clk per bit (data phase, then clock-high phase).
// ready is also raised in the final clock-high phase so a new frame can follow with no gap.
module scanner_ser_tx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] word_i,
  output logic         ready_o,
  output logic         ser_clk_o,
  output logic         ser_data_o,
  output logic         busy_o
);
  localparam int BW = (W > 1) ? $clog2(W) : 1;

  logic          busy;
  logic          phase;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  shreg;
  logic          last;

  assign last    = phase && (bit_cnt == BW'(W - 1));
  assign ready_o = !busy || last;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (load_i && ready_o) begin
      busy    <= 1'b1;
      phase   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= word_i;
    end else if (busy) begin
      if (!phase) begin
        phase <= 1'b1;
      end else if (last) begin
        busy    <= 1'b0;
        phase   <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        phase   <= 1'b0;
        bit_cnt <= bit_cnt + BW'(1);
        shreg   <= shreg >> 1;
      end
    end
  end

  assign ser_clk_o  = phase;
  assign ser_data_o = busy && shreg[0];
  assign busy_o     = busy;

endmodule

// File: rtl/scanner_link.sv
// Scanner node: free-running sample tick, saturating fill counter, latched threshold commands
// arbitrated onto the serializer, and a CMD_DATA + payload transfer that the peer can cut short.
module scanner_link
  import scanner_pkg::*;
#(
  parameter int DEPTH     = 10,
  parameter int WARN_LVL  = 8,
  parameter int START_LVL = 9,
  parameter int W         = 8,
  parameter int DIV       = 8
) (
  input logic          clk,
  input logic          rst,
  scanner_link_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  state_t     state, state_nxt;
  xfer_step_t step, step_nxt;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [FW-1:0] fill, fill_nxt;
  logic flag_ready, flag_ready_nxt;
  logic flag_start, flag_start_nxt;
  logic flag_full, flag_full_nxt;
  logic full_sent, full_sent_nxt;
  logic abort_q, abort_nxt;
  logic          tx_load;
  logic [W-1:0]  tx_word;
  logic          tx_ready;
  logic          tx_busy;
  logic          drop;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= XF_CMD;
      fill       <= '0;
      flag_ready <= 1'b0;
      flag_start <= 1'b0;
      flag_full  <= 1'b0;
      full_sent  <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      fill       <= fill_nxt;
      flag_ready <= flag_ready_nxt;
      flag_start <= flag_start_nxt;
      flag_full  <= flag_full_nxt;
      full_sent  <= full_sent_nxt;
      abort_q    <= abort_nxt;
    end
  end

  // Once the peer reports half-full, nothing beyond the frame on the wire is started.
  assign drop = abort_q || bus.peer_half_i;

  always_comb begin
    state_nxt      = state;
    step_nxt       = step;
    fill_nxt       = fill;
    flag_ready_nxt = flag_ready;
    flag_start_nxt = flag_start;
    flag_full_nxt  = flag_full;
    full_sent_nxt  = full_sent;
    abort_nxt      = abort_q;
    tx_load        = 1'b0;
    tx_word        = '0;

    case (state)
      IDLE: begin
        if (bus.start_i) state_nxt = ACTIVE;
      end

      ACTIVE: begin
        if (tx_ready) begin
          if (flag_ready) begin
            tx_load        = 1'b1;
            tx_word        = W'(CMD_READY);
            flag_ready_nxt = 1'b0;
          end else if (flag_start) begin
            tx_load        = 1'b1;
            tx_word        = W'(CMD_START);
            flag_start_nxt = 1'b0;
          end else if (flag_full) begin
            tx_load       = 1'b1;
            tx_word       = W'(CMD_FULL);
            flag_full_nxt = 1'b0;
            full_sent_nxt = 1'b1;
          end
        end
        // Flags are set after arbitration so a fresh threshold is never cleared unsent.
        if (tick && (fill != FW'(DEPTH))) begin
          fill_nxt = fill + FW'(1);
          if (fill_nxt == FW'(WARN_LVL))  flag_ready_nxt = 1'b1;
          if (fill_nxt == FW'(START_LVL)) flag_start_nxt = 1'b1;
          if (fill_nxt == FW'(DEPTH))     flag_full_nxt  = 1'b1;
        end
        if (full_sent && !tx_busy) state_nxt = bus.ready_xfer_i ? TRANSFER : STANDBY;
      end

      STANDBY: begin
        if (bus.ready_xfer_i || bus.peer_half_i) state_nxt = TRANSFER;
      end

      TRANSFER: begin
        abort_nxt = abort_q || bus.peer_half_i;
        case (step)
          XF_CMD: begin
            if (tx_ready) begin
              tx_load  = 1'b1;
              tx_word  = W'(CMD_DATA);
              step_nxt = XF_PAYLOAD;
            end
          end
          XF_PAYLOAD: begin
            if (drop) begin
              if (!tx_busy) step_nxt = XF_DRAIN;
            end else if (tx_ready) begin
              tx_load  = 1'b1;
              tx_word  = W'(fill);
              step_nxt = XF_DRAIN;
            end
          end
          default: ;
        endcase
        if ((step == XF_DRAIN || (step == XF_PAYLOAD && drop)) && !tx_busy) begin
          state_nxt     = IDLE;
          step_nxt      = XF_CMD;
          fill_nxt      = '0;
          full_sent_nxt = 1'b0;
          abort_nxt     = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  scanner_ser_tx #(.W(W)) u_tx (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .word_i     (tx_word),
    .ready_o    (tx_ready),
    .ser_clk_o  (bus.ser_clk_o),
    .ser_data_o (bus.ser_data_o),
    .busy_o     (tx_busy)
  );

  assign bus.busy_o  = tx_busy;
  assign bus.state_o = state;
  assign bus.fill_o  = fill;

endmodule

// File: tb/tb_scanner_link.sv
// Bench for scanner_link: DIV=2 and DIV=1 nodes driven with randomized scan cycles; a serial-link
// monitor decodes frames and checks them against the expected frame sequence for each cycle.
module tb_scanner_link;
  import scanner_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 10;
  localparam int FW    = 4;

  typedef struct {
    logic [W-1:0] word;
    bit           b2b;
  } frame_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  logic start_v [2];
  logic peer_v  [2];
  logic rdy_v   [2];

  always #5 clk = ~clk;

  scanner_link_if #(.FILL_W(FW)) bus0 ();
  scanner_link_if #(.FILL_W(FW)) bus1 ();

  assign bus0.start_i      = start_v[0];
  assign bus0.peer_half_i  = peer_v[0];
  assign bus0.ready_xfer_i = rdy_v[0];
  assign bus1.start_i      = start_v[1];
  assign bus1.peer_half_i  = peer_v[1];
  assign bus1.ready_xfer_i = rdy_v[1];

  scanner_link #(.DEPTH(DEPTH), .WARN_LVL(8), .START_LVL(9), .W(W), .DIV(2)) dut0 (
    .clk (clk),
    .rst (rst0),
    .bus (bus0.slave)
  );

  scanner_link #(.DEPTH(DEPTH), .WARN_LVL(8), .START_LVL(9), .W(W), .DIV(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  frame_t       exp0[$];
  frame_t       exp1[$];
  int           checks = 0;
  int           passes = 0;
  int           cyc = 0;
  int           bit_cnt   [2];
  logic [W-1:0] shift     [2];
  bit           prev_clk  [2];
  bit           prev_busy [2];
  bit           new_b2b   [2];
  int           last_edge [2];
  int           fill_prev [2];
  int           last_inc  [2];
  bit           inc_valid [2];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int st(input int w);
    return (w == 0) ? int'(bus0.state_o) : int'(bus1.state_o);
  endfunction

  function automatic int fill_of(input int w);
    return (w == 0) ? int'(bus0.fill_o) : int'(bus1.fill_o);
  endfunction

  function automatic int busy_of(input int w);
    return (w == 0) ? int'(bus0.busy_o) : int'(bus1.busy_o);
  endfunction

  task automatic push_frame(input int w, input int code, input bit b2b);
    frame_t f;
    f.word = W'(code);
    f.b2b  = b2b;
    if (w == 0) exp0.push_back(f);
    else        exp1.push_back(f);
  endtask

  // Decodes frames from ser_clk rising edges and checks fill stepping, per node.
  task automatic monitor_step(input int w, input logic r, input logic sclk, input logic sdata,
                              input logic busy, input int fill, input int div);
    frame_t e;
    bit     have;
    if (r) begin
      bit_cnt[w]   = 0;
      prev_clk[w]  = 1'b0;
      prev_busy[w] = 1'b0;
      inc_valid[w] = 1'b0;
      fill_prev[w] = 0;
      last_edge[w] = -100;
      if (w == 0) exp0.delete();
      else        exp1.delete();
      return;
    end
    if (sclk && !prev_clk[w]) begin
      if (bit_cnt[w] == 0) new_b2b[w] = ((cyc - last_edge[w]) == 2);
      shift[w][bit_cnt[w]] = sdata;
      bit_cnt[w]++;
      last_edge[w] = cyc;
      if (bit_cnt[w] == W) begin
        bit_cnt[w] = 0;
        have = 1'b0;
        if (w == 0 && exp0.size() > 0) begin have = 1'b1; e = exp0.pop_front(); end
        if (w == 1 && exp1.size() > 0) begin have = 1'b1; e = exp1.pop_front(); end
        if (!have) begin
          checks++;
          $display("[TB] FAIL unexpected frame dut%0d: got %0d, expected none", w, shift[w]);
        end else begin
          checkOutput($sformatf("frame word dut%0d", w), int'(shift[w]), int'(e.word));
          checkOutput($sformatf("frame gapless dut%0d", w), int'(new_b2b[w]), int'(e.b2b));
        end
      end
    end
    if (prev_busy[w] && !busy)
      checkOutput($sformatf("busy falls on frame edge dut%0d", w), bit_cnt[w], 0);
    if (fill != fill_prev[w]) begin
      if (fill == 0) begin
        inc_valid[w] = 1'b0;
      end else begin
        checkOutput($sformatf("fill step dut%0d", w), fill, fill_prev[w] + 1);
        if (inc_valid[w])
          checkOutput($sformatf("tick interval dut%0d", w), cyc - last_inc[w], div);
        last_inc[w]  = cyc;
        inc_valid[w] = 1'b1;
      end
      fill_prev[w] = fill;
    end
    prev_clk[w]  = sclk;
    prev_busy[w] = busy;
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    monitor_step(0, rst0, bus0.ser_clk_o, bus0.ser_data_o, bus0.busy_o, int'(bus0.fill_o), 2);
    monitor_step(1, rst1, bus1.ser_clk_o, bus1.ser_data_o, bus1.busy_o, int'(bus1.fill_o), 1);
  end

  task automatic wait_state(input int w, input int target, input int budget, input string name);
    int n = 0;
    while (st(w) != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, st(w), target);
  endtask

  // One full scan cycle with randomized transfer path, STANDBY dwell and optional peer abort.
  task automatic applyStimulus(input int w);
    bit xfer     = 1'($urandom_range(0, 1));
    bit abort    = 1'($urandom_range(0, 1));
    bit via_peer = 1'($urandom_range(0, 1));
    int ab       = $urandom_range(0, W - 1);
    int hold     = $urandom_range(1, 3);
    int sb_wait  = $urandom_range(0, 12);

    push_frame(w, CMD_READY, 1'b0);
    push_frame(w, CMD_START, 1'b1);
    push_frame(w, CMD_FULL,  1'b1);
    push_frame(w, CMD_DATA,  1'b0);
    if (!abort) push_frame(w, DEPTH, 1'b1);

    @(negedge clk);
    rdy_v[w]   = xfer;
    start_v[w] = 1'b1;
    repeat (hold) @(negedge clk);
    checkOutput($sformatf("state after start dut%0d", w), st(w), ACTIVE);
    start_v[w] = 1'b0;
    peer_v[w]  = 1'b1;
    repeat (2) @(negedge clk);
    peer_v[w]  = 1'b0;

    if (!xfer) begin
      wait_state(w, STANDBY, 2000, $sformatf("reach STANDBY dut%0d", w));
      checkOutput($sformatf("fill at STANDBY dut%0d", w), fill_of(w), DEPTH);
      repeat (sb_wait) @(negedge clk);
      checkOutput($sformatf("STANDBY held dut%0d", w), st(w), STANDBY);
      checkOutput($sformatf("fill held dut%0d", w), fill_of(w), DEPTH);
      if (via_peer) peer_v[w] = 1'b1;
      else          rdy_v[w]  = 1'b1;
      @(negedge clk);
      peer_v[w] = 1'b0;
      rdy_v[w]  = 1'b0;
      checkOutput($sformatf("enter TRANSFER dut%0d", w), st(w), TRANSFER);
    end else begin
      wait_state(w, TRANSFER, 2000, $sformatf("reach TRANSFER dut%0d", w));
      rdy_v[w] = 1'b0;
    end

    if (abort) begin
      repeat (2 * ab + 1) @(negedge clk);
      peer_v[w] = 1'b1;
      @(negedge clk);
      peer_v[w] = 1'b0;
    end

    wait_state(w, IDLE, 400, $sformatf("back to IDLE dut%0d", w));
    checkOutput($sformatf("fill cleared dut%0d", w), fill_of(w), 0);
    checkOutput($sformatf("busy idle dut%0d", w), busy_of(w), 0);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("scoreboard drained dut%0d", w),
                (w == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      peer_v[i]  = 1'b0;
      rdy_v[i]   = 1'b0;
    end
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset state dut0", int'(bus0.state_o), IDLE);
    checkOutput("reset fill dut0",  int'(bus0.fill_o), 0);
    checkOutput("reset busy dut0",  int'(bus0.busy_o), 0);
    checkOutput("reset sclk dut0",  int'(bus0.ser_clk_o), 0);
    checkOutput("reset sdata dut0", int'(bus0.ser_data_o), 0);
    checkOutput("reset state dut1", int'(bus1.state_o), IDLE);
    checkOutput("reset fill dut1",  int'(bus1.fill_o), 0);
    checkOutput("reset busy dut1",  int'(bus1.busy_o), 0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(0);
      end
      begin
        for (int i = 0; i < 4; i++) applyStimulus(1);
      end
    join

    // Abandon a frame mid-flight with reset, then confirm a clean restart.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!bus0.busy_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy before reset", int'(bus0.busy_o), 1);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    checkOutput("mid-frame reset sclk",  int'(bus0.ser_clk_o), 0);
    checkOutput("mid-frame reset busy",  int'(bus0.busy_o), 0);
    checkOutput("mid-frame reset state", int'(bus0.state_o), IDLE);
    checkOutput("mid-frame reset fill",  int'(bus0.fill_o), 0);
    rst0 = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
